// File: rtl/histeq_pkg.sv
// Shared constants and enumerations for the histogram-equalization controller.
package histeq_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_HIST  = 3'd2,
    ST_CDF   = 3'd3,
    ST_MAP   = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    SEL_NONE  = 3'd0,
    SEL_CLEAR = 3'd1,
    SEL_HIST  = 3'd2,
    SEL_CDF   = 3'd3,
    SEL_MAP   = 3'd4
  } m2_sel_t;

endpackage

// File: rtl/m2_arbiter.sv
// Registered m2 port mux: picks the owner chosen by the controller and presents
// its request one cycle later.
module m2_arbiter
  import histeq_pkg::*;
(
  input  logic              clock,
  input  logic              rst,
  input  m2_sel_t           sel,
  input  logic [ADDR_W-1:0] clear_addr,
  input  logic [ADDR_W-1:0] hist_raddr,
  input  logic [ADDR_W-1:0] hist_waddr,
  input  logic [DATA_W-1:0] hist_wval,
  input  logic              hist_we,
  input  logic [ADDR_W-1:0] cdf_raddr,
  input  logic [ADDR_W-1:0] cdf_waddr,
  input  logic [DATA_W-1:0] cdf_wval,
  input  logic              cdf_we,
  input  logic [ADDR_W-1:0] map_raddr,
  output logic [ADDR_W-1:0] read_addr,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_val,
  output logic              we
);

  logic [ADDR_W-1:0] read_addr_nxt;
  logic [ADDR_W-1:0] write_addr_nxt;
  logic [DATA_W-1:0] write_val_nxt;
  logic              we_nxt;

  // SEL_NONE drives an idle, all-zero request so nothing leaks between owners.
  always_comb begin
    read_addr_nxt  = '0;
    write_addr_nxt = '0;
    write_val_nxt  = '0;
    we_nxt         = 1'b0;
    case (sel)
      SEL_CLEAR: begin
        write_addr_nxt = clear_addr;
        we_nxt         = 1'b1;
      end
      SEL_HIST: begin
        read_addr_nxt  = hist_raddr;
        write_addr_nxt = hist_waddr;
        write_val_nxt  = hist_wval;
        we_nxt         = hist_we;
      end
      SEL_CDF: begin
        read_addr_nxt  = cdf_raddr;
        write_addr_nxt = cdf_waddr;
        write_val_nxt  = cdf_wval;
        we_nxt         = cdf_we;
      end
      SEL_MAP: read_addr_nxt = map_raddr;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      read_addr  <= '0;
      write_addr <= '0;
      write_val  <= '0;
      we         <= 1'b0;
    end else begin
      read_addr  <= read_addr_nxt;
      write_addr <= write_addr_nxt;
      write_val  <= write_val_nxt;
      we         <= we_nxt;
    end
  end

endmodule

// File: rtl/histeq_controller.sv
// Sequences clear -> histogram -> CDF -> mapping, owns the m2 scratchpad during
// the clear, and aborts any phase that overruns its watchdog.
module histeq_controller
  import histeq_pkg::*;
#(
  parameter int CLEAR_DEPTH = 256,
  parameter int TIMEOUT     = 65535
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        phase,
  output logic              hist_start,
  output logic              cdf_start,
  output logic              map_start,
  input  logic              hist_done,
  input  logic              cdf_done,
  input  logic              map_done,
  input  logic [ADDR_W-1:0] hist_m2_raddr,
  input  logic [ADDR_W-1:0] hist_m2_waddr,
  input  logic [ADDR_W-1:0] cdf_m2_raddr,
  input  logic [ADDR_W-1:0] cdf_m2_waddr,
  input  logic [ADDR_W-1:0] map_m2_raddr,
  input  logic [DATA_W-1:0] hist_m2_wval,
  input  logic [DATA_W-1:0] cdf_m2_wval,
  input  logic              hist_m2_we,
  input  logic              cdf_m2_we,
  output logic [ADDR_W-1:0] m2ReadAddr,
  output logic [ADDR_W-1:0] m2WriteAddr,
  output logic [DATA_W-1:0] m2WriteVal,
  output logic              m2WE
);

  localparam logic [ADDR_W-1:0] CLEAR_LAST  = ADDR_W'(CLEAR_DEPTH - 1);
  localparam logic [ADDR_W:0]   TIMEOUT_VAL = (ADDR_W + 1)'(TIMEOUT);

  state_t            state, state_nxt;
  m2_sel_t           sel;
  logic [ADDR_W-1:0] clear_cnt;
  logic [ADDR_W-1:0] clear_addr;
  logic [ADDR_W-1:0] wd_cnt;
  logic              wd_hit;
  logic              in_phase;
  logic              error_q;

  assign in_phase = (state == ST_CLEAR) || (state == ST_HIST) ||
                    (state == ST_CDF)   || (state == ST_MAP);
  // The phase may last TIMEOUT cycles; this fires on the edge that would exceed that.
  assign wd_hit   = ({1'b0, wd_cnt} + {{ADDR_W{1'b0}}, 1'b1}) == TIMEOUT_VAL;

  // Completion is tested before the watchdog so a same-cycle done wins.
  always_comb begin
    state_nxt  = state;
    sel        = SEL_NONE;
    clear_addr = '0;
    case (state)
      ST_IDLE, ST_ERR: if (start) state_nxt = ST_CLEAR;
      ST_CLEAR: begin
        if (clear_cnt == CLEAR_LAST) state_nxt = ST_HIST;
        else if (wd_hit)             state_nxt = ST_ERR;
      end
      ST_HIST: begin
        if (hist_done)   state_nxt = ST_CDF;
        else if (wd_hit) state_nxt = ST_ERR;
      end
      ST_CDF: begin
        if (cdf_done)    state_nxt = ST_MAP;
        else if (wd_hit) state_nxt = ST_ERR;
      end
      ST_MAP: begin
        if (map_done)    state_nxt = ST_DONE;
        else if (wd_hit) state_nxt = ST_ERR;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    // A unit's request is forwarded only while its phase continues past this edge.
    if (state_nxt == ST_CLEAR) begin
      sel        = SEL_CLEAR;
      clear_addr = (state == ST_CLEAR) ? clear_cnt + 1'b1 : '0;
    end else if (state_nxt == state) begin
      case (state)
        ST_HIST: sel = SEL_HIST;
        ST_CDF:  sel = SEL_CDF;
        ST_MAP:  sel = SEL_MAP;
        default: sel = SEL_NONE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= ST_IDLE;
      clear_cnt <= '0;
      wd_cnt    <= '0;
      error_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      clear_cnt <= (state == ST_CLEAR && state_nxt == ST_CLEAR) ? clear_cnt + 1'b1 : '0;
      wd_cnt    <= (in_phase && state_nxt == state) ? wd_cnt + 1'b1 : '0;
      if (state_nxt == ST_CLEAR && state != ST_CLEAR)
        error_q <= 1'b0;
      else if (state_nxt == ST_ERR && state != ST_ERR)
        error_q <= 1'b1;
    end
  end

  assign busy  = (state != ST_IDLE) && (state != ST_ERR);
  assign done  = (state == ST_DONE);
  assign error = error_q;
  assign phase = state;

  // The watchdog reads zero only in the first cycle of a phase.
  assign hist_start = (state == ST_HIST) && (wd_cnt == '0);
  assign cdf_start  = (state == ST_CDF)  && (wd_cnt == '0);
  assign map_start  = (state == ST_MAP)  && (wd_cnt == '0);

  m2_arbiter u_arbiter (
    .clock      (clock),
    .rst        (rst),
    .sel        (sel),
    .clear_addr (clear_addr),
    .hist_raddr (hist_m2_raddr),
    .hist_waddr (hist_m2_waddr),
    .hist_wval  (hist_m2_wval),
    .hist_we    (hist_m2_we),
    .cdf_raddr  (cdf_m2_raddr),
    .cdf_waddr  (cdf_m2_waddr),
    .cdf_wval   (cdf_m2_wval),
    .cdf_we     (cdf_m2_we),
    .map_raddr  (map_m2_raddr),
    .read_addr  (m2ReadAddr),
    .write_addr (m2WriteAddr),
    .write_val  (m2WriteVal),
    .we         (m2WE)
  );

endmodule

// File: tb/tb_histeq_controller.sv
// Directed bench for histeq_controller: a phase-level reference model checked every
// cycle, plus literal expectations for the clear sweep, arbitration, reset and timeout.
module tb_histeq_controller;

  localparam int DEPTH = 256;
  localparam int TMO   = 65535;

  logic         clock;
  logic         rst, start, hist_done, cdf_done, map_done;
  logic [15:0]  hist_m2_raddr, hist_m2_waddr, cdf_m2_raddr, cdf_m2_waddr, map_m2_raddr;
  logic [127:0] hist_m2_wval, cdf_m2_wval;
  logic         hist_m2_we, cdf_m2_we;
  logic         busy, done, error, hist_start, cdf_start, map_start, m2WE;
  logic [2:0]   phase;
  logic [15:0]  m2ReadAddr, m2WriteAddr;
  logic [127:0] m2WriteVal;

  logic         to_rst, to_start, to_hist_done;
  logic         to_busy, to_done, to_error, to_hs, to_cs, to_ms, to_we;
  logic [2:0]   to_phase;
  logic [15:0]  to_raddr, to_waddr;
  logic [127:0] to_wval;

  int vectors = 0;
  int miscompares = 0;
  bit rnd_m2 = 1;

  histeq_controller dut (
    .clock(clock), .rst(rst), .start(start),
    .busy(busy), .done(done), .error(error), .phase(phase),
    .hist_start(hist_start), .cdf_start(cdf_start), .map_start(map_start),
    .hist_done(hist_done), .cdf_done(cdf_done), .map_done(map_done),
    .hist_m2_raddr(hist_m2_raddr), .hist_m2_waddr(hist_m2_waddr),
    .cdf_m2_raddr(cdf_m2_raddr), .cdf_m2_waddr(cdf_m2_waddr),
    .map_m2_raddr(map_m2_raddr),
    .hist_m2_wval(hist_m2_wval), .cdf_m2_wval(cdf_m2_wval),
    .hist_m2_we(hist_m2_we), .cdf_m2_we(cdf_m2_we),
    .m2ReadAddr(m2ReadAddr), .m2WriteAddr(m2WriteAddr),
    .m2WriteVal(m2WriteVal), .m2WE(m2WE)
  );

  histeq_controller #(.CLEAR_DEPTH(4), .TIMEOUT(20)) dut_to (
    .clock(clock), .rst(to_rst), .start(to_start),
    .busy(to_busy), .done(to_done), .error(to_error), .phase(to_phase),
    .hist_start(to_hs), .cdf_start(to_cs), .map_start(to_ms),
    .hist_done(to_hist_done), .cdf_done(1'b0), .map_done(1'b0),
    .hist_m2_raddr(16'h0), .hist_m2_waddr(16'h0),
    .cdf_m2_raddr(16'h0), .cdf_m2_waddr(16'h0),
    .map_m2_raddr(16'h0),
    .hist_m2_wval(128'h0), .cdf_m2_wval(128'h0),
    .hist_m2_we(1'b0), .cdf_m2_we(1'b0),
    .m2ReadAddr(to_raddr), .m2WriteAddr(to_waddr),
    .m2WriteVal(to_wval), .m2WE(to_we)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: phase-level behaviour, stepped on each rising edge.
  bit           model_valid = 0;
  int           m_phase = 0, m_cnt = 0;
  bit           m_err = 0;
  logic [2:0]   e_starts = '0;
  logic [15:0]  e_raddr = '0, e_waddr = '0;
  logic [127:0] e_wval = '0;
  logic         e_we = 1'b0;

  always @(posedge clock) begin
    int nxt;
    if (rst) begin
      model_valid = 1;
      m_phase = 0; m_cnt = 0; m_err = 0; e_starts = '0;
      e_raddr = '0; e_waddr = '0; e_wval = '0; e_we = 1'b0;
    end else if (model_valid) begin
      nxt = m_phase;
      case (m_phase)
        0, 6: if (start) begin nxt = 1; m_err = 0; end
        1: if (m_cnt == DEPTH - 1) nxt = 2; else if (m_cnt + 1 == TMO) nxt = 6;
        2: if (hist_done) nxt = 3; else if (m_cnt + 1 == TMO) nxt = 6;
        3: if (cdf_done)  nxt = 4; else if (m_cnt + 1 == TMO) nxt = 6;
        4: if (map_done)  nxt = 5; else if (m_cnt + 1 == TMO) nxt = 6;
        default: nxt = 0;
      endcase
      if (nxt == 6 && m_phase != 6) m_err = 1;
      m_cnt = (nxt == m_phase) ? m_cnt + 1 : 0;
      e_raddr = '0; e_waddr = '0; e_wval = '0; e_we = 1'b0;
      if (nxt == 1) begin
        e_waddr = 16'(m_cnt); e_we = 1'b1;
      end else if (nxt == m_phase && nxt == 2) begin
        e_raddr = hist_m2_raddr; e_waddr = hist_m2_waddr; e_wval = hist_m2_wval; e_we = hist_m2_we;
      end else if (nxt == m_phase && nxt == 3) begin
        e_raddr = cdf_m2_raddr; e_waddr = cdf_m2_waddr; e_wval = cdf_m2_wval; e_we = cdf_m2_we;
      end else if (nxt == m_phase && nxt == 4) begin
        e_raddr = map_m2_raddr;
      end
      e_starts = '0;
      if (nxt != m_phase) begin
        if (nxt == 2) e_starts = 3'b100;
        if (nxt == 3) e_starts = 3'b010;
        if (nxt == 4) e_starts = 3'b001;
      end
      m_phase = nxt;
    end
  end

  bit          record_on = 0;
  int          last_phase = 0;
  int          seq_q[$];
  logic [15:0] clear_q[$];
  int          done_cnt = 0, hs_cnt = 0, cs_cnt = 0, ms_cnt = 0;

  always @(negedge clock) begin
    if (model_valid) begin
      checkOutput("phase", 128'(phase), 128'(m_phase));
      checkOutput("busy", 128'(busy), 128'(m_phase != 0 && m_phase != 6));
      checkOutput("done", 128'(done), 128'(m_phase == 5));
      checkOutput("error", 128'(error), 128'(m_err));
      checkOutput("starts", 128'({hist_start, cdf_start, map_start}), 128'(e_starts));
      checkOutput("m2WE", 128'(m2WE), 128'(e_we));
      checkOutput("m2ReadAddr", 128'(m2ReadAddr), 128'(e_raddr));
      checkOutput("m2WriteAddr", 128'(m2WriteAddr), 128'(e_waddr));
      checkOutput("m2WriteVal", m2WriteVal, e_wval);
    end
    if (record_on) begin
      if (int'(phase) != last_phase) begin
        seq_q.push_back(int'(phase));
        last_phase = int'(phase);
      end
      if (phase == 3'd1 && m2WE) clear_q.push_back(m2WriteAddr);
      if (done) done_cnt++;
      if (hist_start) hs_cnt++;
      if (cdf_start) cs_cnt++;
      if (map_start) ms_cnt++;
    end
  end

  task automatic applyStimulus(input logic r, input logic s, input logic hd,
                               input logic cd, input logic md);
    rst = r; start = s; hist_done = hd; cdf_done = cd; map_done = md;
    if (rnd_m2) begin
      hist_m2_raddr = 16'($urandom); hist_m2_waddr = 16'($urandom);
      cdf_m2_raddr  = 16'($urandom); cdf_m2_waddr  = 16'($urandom);
      map_m2_raddr  = 16'($urandom);
      hist_m2_wval  = {$urandom, $urandom, $urandom, $urandom};
      cdf_m2_wval   = {$urandom, $urandom, $urandom, $urandom};
      hist_m2_we    = ($urandom_range(0, 3) != 0);
      cdf_m2_we     = ($urandom_range(0, 3) != 0);
    end
    @(posedge clock);
    #2;
  endtask

  task automatic waitPhase(input logic [2:0] p, input int limit);
    int n = 0;
    while (phase != p && n < limit) begin
      applyStimulus(0, 0, 0, 0, 0);
      n++;
    end
    if (phase != p) checkOutput("wait_phase", 128'(phase), 128'(p));
  endtask

  initial begin
    int exp_seq[6] = '{1, 2, 3, 4, 5, 0};
    int bad_addr;
    int n;
    rst = 1; start = 0; hist_done = 0; cdf_done = 0; map_done = 0;
    to_rst = 1; to_start = 0; to_hist_done = 0;
    hist_m2_raddr = '0; hist_m2_waddr = '0; cdf_m2_raddr = '0; cdf_m2_waddr = '0;
    map_m2_raddr = '0; hist_m2_wval = '0; cdf_m2_wval = '0; hist_m2_we = 0; cdf_m2_we = 0;

    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("reset_phase", 128'(phase), 128'd0);
    checkOutput("reset_m2", 128'({m2WE, m2WriteAddr, m2ReadAddr}), 128'd0);

    // Full run: units answer 5/10/7 cycles after their start pulse.
    $display("[TB] full equalization run");
    record_on = 1; last_phase = 0;
    applyStimulus(0, 1, 0, 0, 0);
    waitPhase(3'd2, 400);
    checkOutput("hist_start_first", 128'({hist_start, cdf_start, map_start}), 128'b100);
    applyStimulus(0, 0, 0, 0, 0);
    rnd_m2 = 0;
    hist_m2_we = 1; hist_m2_waddr = 16'h0012; hist_m2_wval = 128'h5; hist_m2_raddr = 16'h0007;
    cdf_m2_we = 1;  cdf_m2_waddr = 16'h0034;  cdf_m2_wval = 128'h9;  cdf_m2_raddr = 16'h0033;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("arb_we", 128'(m2WE), 128'd1);
    checkOutput("arb_waddr", 128'(m2WriteAddr), 128'h0012);
    checkOutput("arb_wval", m2WriteVal, 128'h5);
    rnd_m2 = 1;
    for (int i = 2; i < 5; i++) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("enter_cdf", 128'(phase), 128'd3);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, (i == 2), 0, 0);
    checkOutput("cdf_ignores_hist_done", 128'(phase), 128'd3);
    applyStimulus(0, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) applyStimulus(0, (i == 3), 0, 0, 0);
    checkOutput("map_ignores_start", 128'(phase), 128'd4);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("done_pulse", 128'(done), 128'd1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
    record_on = 0;

    checkOutput("seq_len", 128'(seq_q.size()), 128'd6);
    if (seq_q.size() == 6)
      for (int i = 0; i < 6; i++) checkOutput("seq_step", 128'(seq_q[i]), 128'(exp_seq[i]));
    checkOutput("done_count", 128'(done_cnt), 128'd1);
    checkOutput("start_counts", 128'({8'(hs_cnt), 8'(cs_cnt), 8'(ms_cnt)}), 128'h010101);
    checkOutput("clear_writes", 128'(clear_q.size()), 128'd256);
    bad_addr = 0;
    for (int i = 0; i < clear_q.size(); i++) if (clear_q[i] != 16'(i)) bad_addr++;
    checkOutput("clear_addr_order", 128'(bad_addr), 128'd0);

    // Reset in the middle of the clear sweep, then restart.
    $display("[TB] reset during clear");
    applyStimulus(0, 1, 0, 0, 0);
    waitPhase(3'd1, 10);
    for (int i = 0; i < 100; i++) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("clear_at_100", 128'(m2WriteAddr), 128'd100);
    applyStimulus(1, 0, 1, 1, 1);
    checkOutput("rst_outputs", 128'({busy, done, error, hist_start, cdf_start, map_start, m2WE}), 128'd0);
    checkOutput("rst_addr", 128'({phase, m2ReadAddr, m2WriteAddr}), 128'd0);
    checkOutput("rst_wval", m2WriteVal, 128'd0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("restart_addr", 128'({m2WE, m2WriteAddr}), 128'h10000);

    // Done asserted in the very first HIST cycle.
    waitPhase(3'd2, 300);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("early_done_phase", 128'(phase), 128'd3);
    checkOutput("early_done_cdf_start", 128'(cdf_start), 128'd1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("cdf_start_once", 128'(cdf_start), 128'd0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("second_done", 128'(done), 128'd1);
    applyStimulus(0, 0, 0, 0, 0);

    // Watchdog on the small instance: CDF never completes.
    $display("[TB] watchdog timeout");
    to_rst = 0; to_start = 1;
    applyStimulus(0, 0, 0, 0, 0);
    to_start = 0; to_hist_done = 1;
    n = 0;
    while (to_phase != 3'd3 && n < 50) begin applyStimulus(0, 0, 0, 0, 0); n++; end
    checkOutput("to_reach_cdf", 128'(to_phase), 128'd3);
    n = 0;
    while (to_phase == 3'd3 && n < 100) begin applyStimulus(0, 0, 0, 0, 0); n++; end
    checkOutput("to_cycles", 128'(n), 128'd20);
    checkOutput("to_state", 128'({to_phase, to_error, to_busy, to_we}), 128'({3'd6, 3'b100}));
    checkOutput("to_quiet", 128'({to_done, to_hs, to_cs, to_ms, to_raddr, to_waddr}), 128'd0);
    checkOutput("to_wval", to_wval, 128'd0);
    to_start = 1;
    applyStimulus(0, 0, 0, 0, 0);
    to_start = 0;
    checkOutput("to_restart", 128'({to_phase, to_error, to_busy}), 128'({3'd1, 2'b01}));
    applyStimulus(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
